// File: rtl/counter_4digit.sv
// rtl/counter_4digit.sv - pausable up/down 0..MAX counter with prescaled tick, preload and start/stop toggle
module counter_4digit #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int N        = 10,
    parameter int MAX      = 999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_ss,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         running,
    output logic         tick,
    output logic         wrap
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [N-1:0]  MAX_N   = N'(MAX);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          btn_ss_q;
    logic          btn_edge;
    logic          step;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [N-1:0]  count_d;
    logic          tick_d;
    logic          wrap_d;

    assign btn_edge = btn_ss & ~btn_ss_q;
    assign step     = (state_q == RUN) && (presc_q == PS_LAST);
    assign running  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (btn_edge) begin
            state_d = (state_q == IDLE) ? RUN : IDLE;
        end

        if (state_q == RUN) begin
            presc_d = step ? '0 : presc_q + 1'b1;
        end

        // Load overrides any step in the same cycle; the run state still toggles.
        if (load) begin
            count_d = (load_val > MAX_N) ? MAX_N : load_val;
            presc_d = '0;
        end else if (step) begin
            tick_d = 1'b1;
            if (up) begin
                if (count == MAX_N) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_d = MAX_N;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            btn_ss_q <= 1'b0;
            presc_q  <= '0;
            count    <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_ss_q <= btn_ss;
            presc_q  <= presc_d;
            count    <= count_d;
            tick     <= tick_d;
            wrap     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_counter_4digit.sv
// tb/tb_counter_4digit.sv - directed vector bench for counter_4digit with DIV=4, MAX=999
module tb_counter_4digit;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_ss;
    logic         up;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] count;
    logic         running;
    logic         tick;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_4digit #(
        .CLK_FREQ(4),
        .TICK_HZ (1),
        .N       (N),
        .MAX     (999)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_ss  (btn_ss),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .running (running),
        .tick    (tick),
        .wrap    (wrap)
    );

    typedef struct {
        logic         r;
        logic         b;
        logic         u;
        logic         l;
        logic [N-1:0] lv;
        logic [N-1:0] e_count;
        logic         e_run;
        logic         e_tick;
        logic         e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic r, input logic b, input logic u, input logic l,
                       input logic [N-1:0] lv, input logic [N-1:0] ec,
                       input logic er, input logic et, input logic ew);
        vec_t v;
        v.r = r; v.b = b; v.u = u; v.l = l; v.lv = lv;
        v.e_count = ec; v.e_run = er; v.e_tick = et; v.e_wrap = ew;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive inputs for one cycle, then compare the registered outputs just after the edge.
    task automatic apply(input string tag, input logic r, input logic b, input logic u, input logic l,
                         input logic [N-1:0] lv, input logic [N-1:0] ec,
                         input logic er, input logic et, input logic ew);
        rst = r; btn_ss = b; up = u; load = l; load_val = lv;
        @(posedge clk);
        #1;
        chk({tag, ".count"},   int'(count),   int'(ec));
        chk({tag, ".running"}, int'(running), int'(er));
        chk({tag, ".tick"},    int'(tick),    int'(et));
        chk({tag, ".wrap"},    int'(wrap),    int'(ew));
    endtask

    initial begin
        rst = 1'b1; btn_ss = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

        // reset, start, count 0..3
        add(3, 1, 0, 1, 0, 0,    0,   0, 0, 0);
        add(1, 0, 1, 1, 0, 0,    0,   1, 0, 0);
        add(3, 0, 0, 1, 0, 0,    0,   1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    1,   1, 1, 0);
        add(3, 0, 0, 1, 0, 0,    1,   1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    2,   1, 1, 0);
        add(3, 0, 0, 1, 0, 0,    2,   1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    3,   1, 1, 0);
        // up wrap 998 -> 999 -> 0
        add(1, 0, 0, 1, 1, 998,  998, 1, 0, 0);
        add(3, 0, 0, 1, 0, 0,    998, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    999, 1, 1, 0);
        add(3, 0, 0, 1, 0, 0,    999, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    0,   1, 1, 1);
        add(1, 0, 0, 1, 0, 0,    0,   1, 0, 0);
        // down wrap 1 -> 0 -> 999
        add(1, 0, 0, 0, 1, 1,    1,   1, 0, 0);
        add(3, 0, 0, 0, 0, 0,    1,   1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    0,   1, 1, 0);
        add(3, 0, 0, 0, 0, 0,    0,   1, 0, 0);
        add(1, 0, 0, 0, 0, 0,    999, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0,    999, 1, 0, 0);
        // saturation, then load on the step cycle
        add(1, 0, 0, 1, 1, 1023, 999, 1, 0, 0);
        add(3, 0, 0, 1, 0, 0,    999, 1, 0, 0);
        add(1, 0, 0, 1, 1, 5,    5,   1, 0, 0);
        add(3, 0, 0, 1, 0, 0,    5,   1, 0, 0);
        add(1, 0, 0, 1, 0, 0,    6,   1, 1, 0);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].b, vecs[i].u, vecs[i].l, vecs[i].lv,
                  vecs[i].e_count, vecs[i].e_run, vecs[i].e_tick, vecs[i].e_wrap);
        end

        // held button: one toggle only, prescaler frozen at 2
        apply("hold_pre", 0, 0, 1, 0, 0, 6, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            apply($sformatf("hold%0d", i), 0, 1, 1, 0, 0, 6, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            apply($sformatf("paused%0d", i), 0, 0, 1, 0, 0, 6, 0, 0, 0);
        apply("resume",   0, 1, 1, 0, 0, 6, 1, 0, 0);
        apply("resume+1", 0, 0, 1, 0, 0, 6, 1, 0, 0);
        apply("resume+2", 0, 0, 1, 0, 0, 7, 1, 1, 0);

        // reset on a wrapping step
        apply("ld999", 0, 0, 1, 1, 999, 999, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            apply($sformatf("pre_rst%0d", i), 0, 0, 1, 0, 0, 999, 1, 0, 0);
        apply("rst_step", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            apply($sformatf("post_rst%0d", i), 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // button edge on the step cycle, then button edge together with load
        apply("start2", 0, 1, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            apply($sformatf("run2_%0d", i), 0, 0, 1, 0, 0, 0, 1, 0, 0);
        apply("stop_on_step", 0, 1, 1, 0, 0, 1, 0, 1, 0);
        apply("stopped",      0, 0, 1, 0, 0, 1, 0, 0, 0);
        apply("btn_and_load", 0, 1, 1, 1, 7, 7, 1, 0, 0);
        apply("after_bl",     0, 0, 1, 0, 0, 7, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_4digit.md
# counter_4digit

Free-running, pausable decimal-range counter that produces the binary value consumed by the 4-digit BCD display stage. It divides the board clock into a count tick, counts up or down between 0 and a parameterised maximum with wrap-around, and accepts a synchronous preload. It also provides a start/stop toggle driven by a pre-debounced push-button. Its `count` output connects directly to the display stage's `bcd_in`.

## Interface
- `CLK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `TICK_HZ`, default 1: count rate in Hz. `DIV = CLK_FREQ / TICK_HZ` must be ≥ 2.
- `N`, default 10: width of `count` and `load_val`. Matches the display stage input width.
- `MAX`, default 999: terminal count. Must satisfy `MAX < 2**N`.
- `clk` in 1: single system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_ss` in 1: start/stop button, already debounced and synchronous. Each rising edge toggles run state.
- `up` in 1: direction. 1 = count up, 0 = count down. Sampled on every tick.
- `load` in 1: synchronous preload strobe. Level-sensitive; acts on every cycle it is high.
- `load_val` in N: preload value.
- `count` out N: current count, registered.
- `running` out 1: high in state RUN.
- `tick` out 1: one-cycle pulse on each count step.
- `wrap` out 1: one-cycle pulse when a step wraps (MAX→0 or 0→MAX).

## Operation
- **State machine, 2 states:**
  - IDLE (reset state): prescaler and `count` hold.
  - RUN: prescaler advances every cycle.
  - Transitions: IDLE→RUN and RUN→IDLE on each detected rising edge of `btn_ss`.
  - Edge detect: a registered copy of `btn_ss`; edge = `btn_ss & ~btn_ss_q`. A held button toggles once only.
- **Prescaler:**
  - Width `$clog2(DIV)`. In RUN it counts 0..DIV-1, then returns to 0.
  - The step condition is prescaler == DIV-1 in RUN.
  - Leaving RUN freezes the prescaler at its current value. Resuming continues from that value; the prescaler is not cleared.
- **Count step, when the step condition holds:**
  - `up=1`: `count==MAX` → 0 with `wrap` pulse; otherwise `count+1`.
  - `up=0`: `count==0` → MAX with `wrap` pulse; otherwise `count-1`.
  - `count` never leaves 0..MAX.
- **Load:** highest priority after `rst`.
  - `count` ← `load_val`, saturated to MAX if `load_val > MAX`.
  - Prescaler ← 0.
  - The step is suppressed that cycle: no `tick`, no `wrap`.
  - Load works in both IDLE and RUN and does not change state.
- **Simultaneous events:**
  - `load` with a step condition: load wins and the step is lost.
  - `btn_ss` edge with a step condition in RUN: the step completes and the state goes to IDLE on the same edge.
  - `btn_ss` edge and `load` together: both take effect.
- **Reset values:**
  - `count` = 0, `running` = 0, `tick` = 0, `wrap` = 0.
  - State IDLE, prescaler 0, `btn_ss_q` = 0.
  - Reset mid-count abandons the count immediately, with no pending pulse.
- **Arithmetic:** all compares are unsigned at N bits. Increment and decrement are computed at N bits; wrap is handled explicitly, never by overflow.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Step latency:
  - Prescaler = DIV-1 during cycle k.
  - At the edge ending k: `count` takes its new value, `tick` = 1, and `wrap` = 1 if wrapped.
  - These are visible in cycle k+1. `tick` and `wrap` return to 0 in k+2.
- Step period in continuous RUN is exactly DIV cycles.
- After the first edge out of reset with RUN entered at cycle j (edge seen in j), the first `tick` appears in cycle j+DIV+1 when the prescaler starts at 0.
- `btn_ss` rising in cycle j → `running` = 1 in cycle j+1.
- `load` high in cycle j → new `count` in cycle j+1.

## Test plan
Bench parameters: `CLK_FREQ=4`, `TICK_HZ=1` (DIV=4), `N=10`, `MAX=999`.
- **Reset and start:** hold `rst` 3 cycles → all outputs 0. Pulse `btn_ss` one cycle, `up=1` → `running`=1 next cycle; `tick` every 4 cycles; `count` steps 0,1,2,3.
- **Up wrap:** `load_val=998` then run up → `count` 998→999→0. `wrap`=1 only in the cycle `count` first reads 0.
- **Down wrap:** `load_val=1`, `up=0` → `count` 1→0→999. `wrap` pulses with 999.
- **Load saturation and priority:** `load_val=1023` → `count`=999. Assert `load` with `load_val=5` in the step cycle → `count`=5, `tick`=0; next `tick` 4 cycles later gives `count`=6.
- **Pause/resume and held button:** hold `btn_ss` high 10 cycles → one toggle only. Pause mid-period at prescaler 2 → `count` frozen. Resume → next `tick` 2 cycles after resume.
- **Reset mid-operation:** assert `rst` in the same cycle as a step condition at `count=999`, `up=1` → `count`=0, `wrap`=0, `tick`=0, `running`=0 next cycle.
